// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pkg
// Brief    : Shared encodings for the MIPS CPU multiply/divide unit.
// Revision : 1.0
// ============================================================================
package mips_cpu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } multdiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } multdiv_state_t;

   // The four arithmetic ops occupy the lower half of the encoding space.
   function automatic logic is_arith(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_multdiv_step.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_multdiv_step
// Brief    : One iteration of shift-add multiply or restoring divide.
// Revision : 1.0
// ============================================================================
module mips_cpu_multdiv_step #(
   parameter int WIDTH = 32
)(
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_out
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shifted;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend}.
   always_comb begin
      w_sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc_in[0] ? operand : {WIDTH{1'b0}})};
      w_shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
      w_ge      = (w_shifted >= {1'b0, operand});
      w_diff    = w_shifted[WIDTH-1:0] - operand;
      if (is_div) begin
         if (w_ge)
            acc_out = {w_diff, acc_in[WIDTH-2:0], 1'b1};
         else
            acc_out = {w_shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
         acc_out = {w_sum, acc_in[WIDTH-1:1]};
      end
   end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_multdiv.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_multdiv
// Brief    : Iterative MULT/DIV unit with architectural HI/LO registers.
// Revision : 1.0
// ============================================================================
module mips_cpu_multdiv
   import mips_cpu_pkg::*;
#(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int                 c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

   multdiv_state_t     r_state, w_state_next;
   logic [c_cnt_w-1:0] r_count;
   logic [2*WIDTH-1:0] r_acc, w_acc_step, w_prod;
   logic [WIDTH-1:0]   r_operand, r_dividend, r_hi, r_lo;
   logic               r_is_div, r_neg_q, r_neg_r, r_done;

   logic               w_accept, w_arith, w_signed, w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_first, w_second;
   logic [WIDTH-1:0]   w_quot, w_rem, w_fix_hi, w_fix_lo;

   assign w_accept = start && (r_state == ST_IDLE);
   assign w_arith  = w_accept && is_arith(op);
   assign w_signed = ~op[0];
   assign w_a_neg  = w_signed & rs_data[WIDTH-1];
   assign w_b_neg  = w_signed & rt_data[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -rs_data : rs_data;
   assign w_b_mag  = w_b_neg ? -rt_data : rt_data;
   // Accumulator seeds with the multiplier (mult) or the dividend (div).
   assign w_first  = op[1] ? w_a_mag : w_b_mag;
   assign w_second = op[1] ? w_b_mag : w_a_mag;

   mips_cpu_multdiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (r_is_div),
      .acc_in  (r_acc),
      .operand (r_operand),
      .acc_out (w_acc_step)
   );

   assign w_prod   = r_neg_q ? -r_acc : r_acc;
   assign w_quot   = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   assign w_fix_hi = !r_is_div ? w_prod[2*WIDTH-1:WIDTH] :
                     (r_operand == '0) ? r_dividend : w_rem;
   assign w_fix_lo = !r_is_div ? w_prod[WIDTH-1:0] :
                     (r_operand == '0) ? DIV0_LO : w_quot;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_arith) w_state_next = ST_CALC;
         ST_CALC: if (r_count == c_last) w_state_next = ST_FIX;
         ST_FIX:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count    <= '0;
         r_acc      <= '0;
         r_operand  <= '0;
         r_dividend <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= (r_state == ST_FIX);
         case (r_state)
            ST_IDLE: begin
               if (w_arith) begin
                  r_acc      <= {{WIDTH{1'b0}}, w_first};
                  r_operand  <= w_second;
                  r_dividend <= rs_data;
                  r_is_div   <= op[1];
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  r_count    <= '0;
               end else if (w_accept && op == OP_MTHI) begin
                  r_hi <= rs_data;
               end else if (w_accept && op == OP_MTLO) begin
                  r_lo <= rs_data;
               end
            end
            ST_CALC: begin
               r_acc   <= w_acc_step;
               r_count <= r_count + c_cnt_w'(1);
            end
            ST_FIX: begin
               r_hi <= w_fix_hi;
               r_lo <= w_fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_multdiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_multdiv
// Brief    : Self-checking bench for the MIPS multiply/divide unit.
// Revision : 1.0
// ============================================================================
module tb_mips_cpu_multdiv;
   import mips_cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op;
   logic [31:0] rs_data, rt_data, hi, lo;
   logic        busy, done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs, rt, hi, lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi, lo;
   } exp_t;

   vec_t vecs[10];
   exp_t sb[$];

   mips_cpu_multdiv #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one request through edge E0, then scramble the operand inputs.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      @(posedge clk); #1;
      start   = 1'b0;
      op      = 3'($urandom_range(0, 7));
      rs_data = $urandom;
      rt_data = $urandom;
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int   cyc = 0;
      logic busy_ok = 1'b1;
      exp_t e;
      for (int i = 1; i <= exp_lat + 8; i++) begin
         @(posedge clk); #1;
         if (done) begin
            cyc = i;
            break;
         end
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      check({name, " latency"}, 32'(cyc), 32'(exp_lat));
      check({name, " busy held"}, {31'd0, busy_ok}, 32'd1);
      check({name, " busy at done"}, {31'd0, busy}, 32'd0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({name, " hi"}, hi, e.hi);
         check({name, " lo"}, lo, e.lo);
      end else begin
         check({name, " scoreboard"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      logic [31:0] prev_lo;
      int          ndone;

      vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[4] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
      vecs[5] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      vecs[7] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
      vecs[8] = '{OP_DIV,   32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
      vecs[9] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

      reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         sb.push_back('{vecs[i].hi, vecs[i].lo});
         issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
         wait_done($sformatf("vec%0d", i), 33);
         @(posedge clk); #1;
         check($sformatf("vec%0d done pulse", i), {31'd0, done}, 32'd0);
      end

      issue(OP_MTHI, 32'h0000_1234, 32'h0);
      check("mthi hi", hi, 32'h0000_1234);
      check("mthi done", {31'd0, done}, 32'd0);
      check("mthi busy", {31'd0, busy}, 32'd0);
      issue(OP_MTLO, 32'hCAFE_0001, 32'h0);
      check("mtlo lo", lo, 32'hCAFE_0001);

      // Requests while busy must be dropped, MTLO included.
      prev_lo = lo;
      sb.push_back('{32'h0, 32'd30});
      issue(OP_MULTU, 32'd5, 32'd6);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = OP_MTLO; rs_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy mtlo ignored", lo, prev_lo);
      start = 1'b1; op = OP_MULT; rs_data = 32'd3; rt_data = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("busy ignore", 27);

      // Back-to-back: issue in the cycle done is high.
      sb.push_back('{32'h0000_0002, 32'h0000_0003});
      issue(OP_DIVU, 32'd17, 32'd5);
      wait_done("b2b first", 33);
      sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFE});
      issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
      check("b2b accepted busy", {31'd0, busy}, 32'd1);
      wait_done("b2b second", 33);

      // Asynchronous reset mid-divide aborts with no result.
      issue(OP_DIVU, 32'd1000, 32'd7);
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort hi", hi, 32'd0);
      check("abort lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("abort no done", 32'(ndone), 32'd0);
      check("abort hi stays", hi, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
